// File: rtl/sram_boot_loader.sv
// Boot loader: streams a length-prefixed big-endian word image into SRAM, then passes the port to the core.
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module sram_boot_loader #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_idata,
  output logic [DATA_W-1:0] cpu_odata,
  input  logic              cpu_cs_,
  input  logic              cpu_rw_,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_idata,
  input  logic [DATA_W-1:0] mem_odata,
  output logic              mem_cs_,
  output logic              mem_rw_,
  output logic              core_rst,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK, S_DONE
  } state_e;

`ifdef CHECKSUM_EN
  localparam state_e S_TAIL = S_CHK;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN_HI;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      wr_addr_q  <= BASE_ADDR;
      word_q     <= '0;
      err_q      <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      wr_addr_q  <= wr_addr_d;
      word_q     <= word_d;
      err_q      <= err_d;
      csum_q     <= csum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    wr_addr_d  = wr_addr_q;
    word_d     = word_q;
    err_d      = err_q;
    csum_d     = csum_q;
    case (state_q)
      S_LEN_HI: if (rx_valid) begin
        len_d[15:8] = rx_data;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (rx_valid) begin
        len_d[7:0] = rx_data;
        state_d    = ({len_q[15:8], rx_data} == 16'd0) ? S_TAIL : S_DATA;
      end
      S_DATA: if (rx_valid) begin
        word_d     = {word_q[DATA_W-9:0], rx_data};
        csum_d     = csum_q ^ rx_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_addr_d  = wr_addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = ((word_cnt_q + 16'd1) == len_q) ? S_TAIL : S_DATA;
      end
      S_CHK: if (rx_valid) begin
        if (rx_data != csum_q) err_d = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_DONE;
    endcase
  end

  // Reset overrides the state-derived port drive so the SRAM is idle while rst is high.
  always_comb begin
    rx_ready  = 1'b0;
    mem_cs_   = 1'b1;
    mem_rw_   = 1'b1;
    mem_addr  = wr_addr_q;
    mem_idata = word_q;
    if (rst) begin
      mem_addr  = BASE_ADDR;
      mem_idata = '0;
    end else begin
      case (state_q)
        S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: rx_ready = 1'b1;
        S_WRITE: begin
          mem_cs_ = 1'b0;
          mem_rw_ = 1'b0;
        end
        S_DONE: begin
          mem_addr  = cpu_addr;
          mem_idata = cpu_idata;
          mem_cs_   = cpu_cs_;
          mem_rw_   = cpu_rw_;
        end
        default: rx_ready = 1'b0;
      endcase
    end
  end

  assign cpu_odata = mem_odata;
  assign boot_done = (state_q == S_DONE);
`ifdef CHECKSUM_EN
  assign boot_err  = err_q;
`else
  assign boot_err  = 1'b0;
`endif
  assign core_rst  = rst | ~boot_done | boot_err;

endmodule
